// File: rtl/pss_pkg.sv
// Purpose: shared PSS constants (m-sequence, per-N_id_2 start pointers) and FSM state type.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Also used by the correlator's local-PSS generation, so keep M_SEQ bit order stable: x(0) at LSB.
package pss_pkg;

    localparam int PSS_LEN = 127;

    // x(i+7) = x(i+4) xor x(i), seeded with [x6..x0] = 1110110.
    function automatic logic [PSS_LEN-1:0] gen_m_seq();
        logic [PSS_LEN-1:0] x;
        x      = '0;
        x[6:0] = 7'b1110110;
        for (int i = 0; i < PSS_LEN - 7; i++) begin
            x[i+7] = x[i+4] ^ x[i];
        end
        return x;
    endfunction

    localparam logic [PSS_LEN-1:0] M_SEQ = gen_m_seq();

    // Sequence pointer at bin 0: (64 + 43*N_id_2) mod 127.
    localparam logic [6:0] P_INIT_0 = 7'd64;
    localparam logic [6:0] P_INIT_1 = 7'd107;
    localparam logic [6:0] P_INIT_2 = 7'd23;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } pss_state_t;

    function automatic logic [6:0] p_init(input logic [1:0] nid);
        logic [6:0] p;
        case (nid)
            2'd1:    p = P_INIT_1;
            2'd2:    p = P_INIT_2;
            default: p = P_INIT_0;
        endcase
        return p;
    endfunction

    // Modulo-127 increment without a divider.
    function automatic logic [6:0] p_next(input logic [6:0] p);
        return (p == 7'(PSS_LEN - 1)) ? 7'd0 : p + 7'd1;
    endfunction

endpackage

// File: rtl/pss_freq_generator_if.sv
// Purpose: AXI-Stream bundle carrying {imag, real} frequency-domain samples.
// Latency: n/a (wires only).
// Backpressure: tready from the slave; master holds tdata/tlast while tvalid && !tready.
interface pss_freq_generator_if #(
    parameter int OUT_DW = 32
) ();
    logic [OUT_DW-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pss_seq_rom.sv
// Purpose: m-sequence lookup, pointer in -> x bit out (swappable for an LFSR later).
// Latency: combinational.
// Backpressure: none.
// Ports: ptr_i (0..126), x_o (x(ptr)); out-of-range pointers read 0.
module pss_seq_rom
    import pss_pkg::*;
(
    input  logic [6:0] ptr_i,
    output logic       x_o
);

    always_comb begin
        x_o = 1'b0;
        if (ptr_i < 7'(PSS_LEN)) begin
            x_o = M_SEQ[ptr_i];
        end
    end

endmodule

// File: rtl/pss_freq_generator.sv
// Purpose: emit one FFT_LEN-bin frequency-domain PSS symbol (natural bin order) per accepted start.
// Latency: start accepted at cycle t -> bin 0 valid at t+1; one bin per cycle when tready is held high.
// Backpressure: AXI-Stream; registered tdata/tlast hold while stalled, tvalid stays high for the whole symbol.
// Ports: clk_i, reset_ni (async active-low), N_id_2_i/start_i request, m_axis_out stream,
//        busy_o (start accepted .. last beat done), error_o (1-cycle pulse on N_id_2_i == 3).
module pss_freq_generator
    import pss_pkg::*;
#(
    parameter int OUT_DW    = 32,
    parameter int FFT_LEN   = 256,
    parameter int AMPLITUDE = 8192
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic [1:0]                  N_id_2_i,
    input  logic                        start_i,
    pss_freq_generator_if.master        m_axis_out,
    output logic                        busy_o,
    output logic                        error_o
);

    localparam int HW = OUT_DW / 2;
    localparam int KW = $clog2(FFT_LEN);

    localparam logic [KW-1:0] K_LAST     = KW'(FFT_LEN - 1);
    localparam logic [KW-1:0] K_LO_END   = KW'(62);           // bins 0..62 carry d(64..126)
    localparam logic [KW-1:0] K_HI_START = KW'(FFT_LEN - 64); // top 64 bins carry d(0..63)
    localparam logic [HW-1:0] AMP_POS    = HW'(AMPLITUDE);
    localparam logic [HW-1:0] AMP_NEG    = HW'(-AMPLITUDE);

    pss_state_t        state_q, state_d;
    logic [KW-1:0]     k_q, k_d;       // bin currently presented on the output register
    logic [6:0]        p_q, p_d;       // sequence pointer for the next PSS bin to be loaded
    logic [OUT_DW-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              error_q, error_d;

    logic [6:0]        rom_ptr;
    logic              rom_x;
    logic [OUT_DW-1:0] pss_word;
    logic [KW-1:0]     k_nxt;
    logic              nxt_is_pss;
    logic              beat;

    // In IDLE the ROM looks up bin 0 for the requested N_id_2; while streaming it
    // looks up the next PSS bin so the output register can be reloaded on a beat.
    always_comb begin
        rom_ptr = p_q;
        if (state_q == ST_IDLE) begin
            rom_ptr = p_init(N_id_2_i);
        end
    end

    pss_seq_rom u_rom (
        .ptr_i (rom_ptr),
        .x_o   (rom_x)
    );

    // BPSK: x = 0 -> d = +1, x = 1 -> d = -1; imag is always zero.
    assign pss_word   = {{HW{1'b0}}, (rom_x ? AMP_NEG : AMP_POS)};
    assign k_nxt      = k_q + KW'(1);
    assign nxt_is_pss = (k_nxt <= K_LO_END) || (k_nxt >= K_HI_START);
    assign beat       = tvalid_q && m_axis_out.tready;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        p_d      = p_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        error_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (N_id_2_i == 2'd3) begin
                        error_d = 1'b1;
                    end else begin
                        // Bin 0 is always a PSS bin; FFT_LEN >= 128 so it is never the last bin.
                        state_d  = ST_STREAM;
                        k_d      = '0;
                        p_d      = p_next(rom_ptr);
                        tdata_d  = pss_word;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                    end
                end
            end

            ST_STREAM: begin
                // start_i is deliberately ignored here, including on the final beat.
                if (beat) begin
                    if (tlast_q) begin
                        state_d  = ST_IDLE;
                        k_d      = '0;
                        p_d      = '0;
                        tdata_d  = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        k_d     = k_nxt;
                        tlast_d = (k_nxt == K_LAST);
                        if (nxt_is_pss) begin
                            tdata_d = pss_word;
                            p_d     = p_next(p_q);
                        end else begin
                            tdata_d = '0;
                        end
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tdata_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            p_q      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            p_q      <= p_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            error_q  <= error_d;
        end
    end

    assign m_axis_out.tdata  = tdata_q;
    assign m_axis_out.tvalid = tvalid_q;
    assign m_axis_out.tlast  = tlast_q;
    assign busy_o            = (state_q == ST_STREAM);
    assign error_o           = error_q;

endmodule

// File: tb/tb_pss_freq_generator.sv
// Purpose: directed bench for pss_freq_generator at FFT_LEN 256 (dut A) and 128 (dut B).
// Latency: n/a.
// Backpressure: bench drives tready, optionally with random stalls.
module tb_pss_freq_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] nid;
    logic       start;
    logic       rdy;
    int         sel;

    logic       start_a, start_b;
    logic       busy_a, busy_b, err_a, err_b;

    pss_freq_generator_if #(.OUT_DW(32)) ifa ();
    pss_freq_generator_if #(.OUT_DW(32)) ifb ();

    assign start_a    = start && (sel == 0);
    assign start_b    = start && (sel == 1);
    assign ifa.tready = rdy;
    assign ifb.tready = rdy;

    pss_freq_generator #(.OUT_DW(32), .FFT_LEN(256), .AMPLITUDE(8192)) u_a (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .N_id_2_i   (nid),
        .start_i    (start_a),
        .m_axis_out (ifa),
        .busy_o     (busy_a),
        .error_o    (err_a)
    );

    pss_freq_generator #(.OUT_DW(32), .FFT_LEN(128), .AMPLITUDE(8192)) u_b (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .N_id_2_i   (nid),
        .start_i    (start_b),
        .m_axis_out (ifb),
        .busy_o     (busy_b),
        .error_o    (err_b)
    );

    // Observation mux for the selected DUT.
    logic [31:0] o_dat;
    logic        o_vld, o_last, o_busy, o_err;
    always_comb begin
        o_dat  = (sel == 1) ? ifb.tdata  : ifa.tdata;
        o_vld  = (sel == 1) ? ifb.tvalid : ifa.tvalid;
        o_last = (sel == 1) ? ifb.tlast  : ifa.tlast;
        o_busy = (sel == 1) ? busy_b     : busy_a;
        o_err  = (sel == 1) ? err_b      : err_a;
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int          checks   = 0;
    int          failures = 0;
    bit          xs [127];
    logic [31:0] cap  [256];
    logic [31:0] ref0 [256];

    localparam logic [31:0] W_POS = 32'h0000_2000;  // real = +8192
    localparam logic [31:0] W_NEG = 32'h0000_E000;  // real = -8192

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected word for bin k: d(n) sits at bin (n - 64) mod fft.
    function automatic logic [31:0] exp_bin(input int fft, input int n_id, input int k);
        int n;
        if (k <= 62)            n = k + 64;
        else if (k >= fft - 64) n = k - (fft - 64);
        else                    return 32'h0;
        return xs[(n + 43 * n_id) % 127] ? W_NEG : W_POS;
    endfunction

    // Starts a symbol on DUT s and consumes it, checking every beat.
    // inj >= 0 pulses an extra start (with a different N_id_2) at that loop cycle.
    task automatic run_sym(input int s, input int n_id, input int stall, input int inj, input int fft,
                           output int tlast_cyc, output int first_cyc);
        int          beats;
        int          cyc;
        bit          pstall;
        logic [31:0] pd;
        logic        pl;
        tlast_cyc = 0;
        sel       = s;
        nid       = 2'(n_id);
        rdy       = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        first_cyc = cyc_cnt;
        check("lat_tvalid", 32'(o_vld), 32'd1);
        check("lat_busy", 32'(o_busy), 32'd1);
        beats  = 0;
        cyc    = 0;
        pstall = 1'b0;
        pd     = '0;
        pl     = 1'b0;
        while (beats < fft && cyc < 4000) begin
            if (pstall) begin
                check("hold_tdata", o_dat, pd);
                check("hold_tlast", 32'(o_last), 32'(pl));
            end
            check("tvalid_high", 32'(o_vld), 32'd1);
            check("no_error", 32'(o_err), 32'd0);
            rdy   = (stall > 0 && $urandom_range(0, 99) < stall) ? 1'b0 : 1'b1;
            start = (cyc == inj);
            if (cyc == inj) nid = 2'((n_id + 1) % 3);
            if (o_vld && rdy) begin
                check("bin_data", o_dat, exp_bin(fft, n_id, beats));
                check("bin_tlast", 32'(o_last), 32'(beats == fft - 1));
                cap[beats] = o_dat;
                if (o_last) tlast_cyc = cyc_cnt;
                beats++;
                pstall = 1'b0;
            end else begin
                pstall = o_vld;
                pd     = o_dat;
                pl     = o_last;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        rdy   = 1'b1;
        check("beat_count", 32'(beats), 32'(fft));
        check("busy_end", 32'(o_busy), 32'd0);
        check("tvalid_end", 32'(o_vld), 32'd0);
    endtask

    initial begin
        int tl, fc, tl1, fc1, tl2, fc2;
        logic [31:0] tbl [7];

        // Reference m-sequence from the recurrence, seeded [x6..x0] = 1110110.
        xs[0] = 0; xs[1] = 1; xs[2] = 1; xs[3] = 0; xs[4] = 1; xs[5] = 1; xs[6] = 1;
        for (int i = 0; i < 120; i++) xs[i+7] = xs[i+4] ^ xs[i];

        reset_n = 1'b0;
        nid     = 2'd0;
        start   = 1'b0;
        rdy     = 1'b1;
        sel     = 0;
        repeat (2) @(negedge clk);

        check("rst_tvalid_a", 32'(ifa.tvalid), 32'd0);
        check("rst_tlast_a", 32'(ifa.tlast), 32'd0);
        check("rst_tdata_a", ifa.tdata, 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_error_a", 32'(err_a), 32'd0);
        check("rst_tvalid_b", 32'(ifb.tvalid), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);

        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // N_id_2 = 0, no stalls: latency, tlast position, spot bins.
        run_sym(0, 0, 0, -1, 256, tl, fc);
        check("tlast_latency", 32'(tl - fc), 32'd255);
        tbl[0] = W_POS; tbl[1] = W_NEG; tbl[2] = W_NEG; tbl[3] = W_POS;
        tbl[4] = W_NEG; tbl[5] = W_NEG; tbl[6] = W_NEG;
        for (int i = 0; i < 7; i++) check("bins_192_198", cap[192+i], tbl[i]);
        check("bin_63_zero", cap[63], 32'd0);
        check("bin_191_zero", cap[191], 32'd0);
        for (int i = 0; i < 256; i++) ref0[i] = cap[i];

        // N_id_2 = 1 and 2, all bins against the model.
        run_sym(0, 1, 0, -1, 256, tl, fc);
        run_sym(0, 2, 0, -1, 256, tl, fc);

        // 30% stalls plus a start / N_id_2 change mid-symbol; result must match the stall-free run.
        run_sym(0, 0, 30, 40, 256, tl, fc);
        for (int i = 0; i < 256; i++) check("stall_vs_ref", cap[i], ref0[i]);
        repeat (3) @(negedge clk);
        check("no_restart", 32'(ifa.tvalid), 32'd0);

        // Illegal N_id_2: one-cycle error, no symbol.
        sel   = 0;
        nid   = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(err_a), 32'd1);
        check("err_busy", 32'(busy_a), 32'd0);
        check("err_tvalid", 32'(ifa.tvalid), 32'd0);
        @(negedge clk);
        check("err_clear", 32'(err_a), 32'd0);
        check("err_tvalid2", 32'(ifa.tvalid), 32'd0);

        // Reset in the middle of a symbol, at bin 100.
        nid   = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("pre_rst_busy", 32'(busy_a), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(ifa.tvalid), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_tdata", ifa.tdata, 32'd0);
        check("mid_rst_tlast", 32'(ifa.tlast), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_sym(0, 0, 0, -1, 256, tl, fc);

        // FFT_LEN = 128, then a back-to-back start the cycle after busy falls.
        run_sym(1, 1, 0, -1, 128, tl1, fc1);
        run_sym(1, 0, 0, -1, 128, tl2, fc2);
        check("b2b_gap", 32'(fc2 - tl1), 32'd2);
        check("b128_bin63", cap[63], 32'd0);
        check("b128_bin0", cap[0], xs[64] ? W_NEG : W_POS);
        check("b128_bin127", cap[127], xs[63] ? W_NEG : W_POS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
